// File: rtl/i2c_pkg.sv
// Shared state encodings, error bit positions and command bundle for the
// I2C master transaction sequencer.
package i2c_pkg;

  typedef logic [3:0] xfer_state_t;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_ADDR_W = 4'd1;
  localparam logic [3:0] ST_REG    = 4'd2;
  localparam logic [3:0] ST_WAIT_W = 4'd3;
  localparam logic [3:0] ST_WR     = 4'd4;
  localparam logic [3:0] ST_ADDR_R = 4'd5;
  localparam logic [3:0] ST_RD     = 4'd6;
  localparam logic [3:0] ST_STOP   = 4'd7;
  localparam logic [3:0] ST_DONE   = 4'd8;

  localparam int unsigned ERR_NACK = 0;
  localparam int unsigned ERR_AL   = 1;

  typedef struct packed {
    logic start;
    logic stop;
    logic read;
    logic write;
  } bc_cmd_t;

  localparam bc_cmd_t BC_NONE = '0;

  function automatic bc_cmd_t bc_cmd(input logic sta, input logic sto,
                                     input logic rd, input logic wr);
    bc_cmd = '{start: sta, stop: sto, read: rd, write: wr};
  endfunction

endpackage

// File: rtl/i2c_master_xfer_seq.sv
// Register-transaction sequencer: turns one host request into START/WRITE/
// READ/STOP commands for the I2C byte controller, with NACK and AL handling.
module i2c_master_xfer_seq
  import i2c_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_i,
  input  logic             rnw_i,
  input  logic [6:0]       dev_addr_i,
  input  logic [7:0]       reg_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [7:0]       wdata_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  output logic [7:0]       rdata_o,
  output logic             rvalid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       err_o,
  output logic             bc_start_o,
  output logic             bc_stop_o,
  output logic             bc_read_o,
  output logic             bc_write_o,
  output logic             bc_ack_o,
  output logic [7:0]       bc_dat_o,
  input  logic             bc_cmd_ack_i,
  input  logic             bc_ack_i,
  input  logic [7:0]       bc_dat_i,
  input  logic             bc_al_i
);

  xfer_state_t      state_q, state_d;
  logic             issued_q, issued_d;
  logic             rnw_q, rnw_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       reg_q, reg_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       wbyte_q, wbyte_d;
  bc_cmd_t          cmd_q, cmd_d;
  logic [7:0]       dat_q, dat_d;
  logic             ack_q, ack_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       err_q, err_d;

  logic cmd_done;
  logic last_byte;

  // issued_q mirrors "a command is on the lines", so an ack only counts then
  assign cmd_done  = issued_q & bc_cmd_ack_i;
  assign last_byte = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    rnw_d    = rnw_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    cnt_d    = cnt_q;
    wbyte_d  = wbyte_q;
    cmd_d    = cmd_q;
    dat_d    = dat_q;
    ack_d    = ack_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    wready_o = 1'b0;

    if (cmd_done) begin
      cmd_d    = BC_NONE;
      issued_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          rnw_d    = rnw_i;
          dev_d    = dev_addr_i;
          reg_d    = reg_addr_i;
          cnt_d    = len_i;
          err_d    = '0;
          busy_d   = 1'b1;
          cmd_d    = bc_cmd(1'b1, 1'b0, 1'b0, 1'b1);
          dat_d    = {dev_addr_i, 1'b0};
          ack_d    = 1'b0;
          issued_d = 1'b1;
          state_d  = ST_ADDR_W;
        end
      end

      ST_ADDR_W: begin
        if (!issued_q) begin
          cmd_d    = bc_cmd(1'b1, 1'b0, 1'b0, 1'b1);
          dat_d    = {dev_q, 1'b0};
          ack_d    = 1'b0;
          issued_d = 1'b1;
        end else if (cmd_done) begin
          if (bc_ack_i) begin
            err_d[ERR_NACK] = 1'b1;
            state_d         = ST_STOP;
          end else begin
            state_d = ST_REG;
          end
        end
      end

      ST_REG: begin
        if (!issued_q) begin
          cmd_d    = bc_cmd(1'b0, 1'b0, 1'b0, 1'b1);
          dat_d    = reg_q;
          ack_d    = 1'b0;
          issued_d = 1'b1;
        end else if (cmd_done) begin
          if (bc_ack_i) begin
            err_d[ERR_NACK] = 1'b1;
            state_d         = ST_STOP;
          end else if (rnw_q) begin
            state_d = ST_ADDR_R;
          end else begin
            state_d = ST_WAIT_W;
          end
        end
      end

      // The byte ctrl keeps SCL low while no command is pending here.
      ST_WAIT_W: begin
        if (wvalid_i) begin
          wready_o = 1'b1;
          wbyte_d  = wdata_i;
          state_d  = ST_WR;
        end
      end

      ST_WR: begin
        if (!issued_q) begin
          cmd_d    = bc_cmd(1'b0, 1'b0, 1'b0, 1'b1);
          dat_d    = wbyte_q;
          ack_d    = 1'b0;
          issued_d = 1'b1;
        end else if (cmd_done) begin
          if (bc_ack_i) begin
            err_d[ERR_NACK] = 1'b1;
            state_d         = ST_STOP;
          end else if (last_byte) begin
            state_d = ST_STOP;
          end else begin
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = ST_WAIT_W;
          end
        end
      end

      ST_ADDR_R: begin
        if (!issued_q) begin
          cmd_d    = bc_cmd(1'b1, 1'b0, 1'b0, 1'b1);
          dat_d    = {dev_q, 1'b1};
          ack_d    = 1'b0;
          issued_d = 1'b1;
        end else if (cmd_done) begin
          if (bc_ack_i) begin
            err_d[ERR_NACK] = 1'b1;
            state_d         = ST_STOP;
          end else begin
            state_d = ST_RD;
          end
        end
      end

      // Last byte is NACKed and carries the STOP, so no separate STOP state.
      ST_RD: begin
        if (!issued_q) begin
          cmd_d    = bc_cmd(1'b0, last_byte, 1'b1, 1'b0);
          ack_d    = last_byte;
          issued_d = 1'b1;
        end else if (cmd_done) begin
          rvalid_d = 1'b1;
          rdata_d  = bc_dat_i;
          if (last_byte) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end

      ST_STOP: begin
        if (!issued_q) begin
          cmd_d    = bc_cmd(1'b0, 1'b1, 1'b0, 1'b0);
          ack_d    = 1'b0;
          issued_d = 1'b1;
        end else if (cmd_done) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        cmd_d    = BC_NONE;
        issued_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    // Lost arbitration overrides any same-cycle ack; DONE has nothing left to drop.
    if (bc_al_i && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      cmd_d         = BC_NONE;
      issued_d      = 1'b0;
      err_d[ERR_AL] = 1'b1;
      rvalid_d      = 1'b0;
      wready_o      = 1'b0;
      state_d       = ST_DONE;
      done_d        = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      issued_q <= 1'b0;
      rnw_q    <= 1'b0;
      dev_q    <= '0;
      reg_q    <= '0;
      cnt_q    <= '0;
      wbyte_q  <= '0;
      cmd_q    <= BC_NONE;
      dat_q    <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      rnw_q    <= rnw_d;
      dev_q    <= dev_d;
      reg_q    <= reg_d;
      cnt_q    <= cnt_d;
      wbyte_q  <= wbyte_d;
      cmd_q    <= cmd_d;
      dat_q    <= dat_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bc_start_o = cmd_q.start;
  assign bc_stop_o  = cmd_q.stop;
  assign bc_read_o  = cmd_q.read;
  assign bc_write_o = cmd_q.write;
  assign bc_ack_o   = ack_q;
  assign bc_dat_o   = dat_q;
  assign rdata_o    = rdata_q;
  assign rvalid_o   = rvalid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_i2c_master_xfer_seq.sv
// Bench for i2c_master_xfer_seq: a behavioural byte-ctrl/slave and host model
// build the expected command list per transaction and score the DUT against it.
`timescale 1ns/1ps
module tb_i2c_master_xfer_seq;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       req_i, rnw_i;
  logic [6:0] dev_addr_i;
  logic [7:0] reg_addr_i;
  logic [3:0] len_i;
  logic [7:0] wdata_i;
  logic       wvalid_i, wready_o;
  logic [7:0] rdata_o;
  logic       rvalid_o, busy_o, done_o;
  logic [1:0] err_o;
  logic       bc_start_o, bc_stop_o, bc_read_o, bc_write_o, bc_ack_o;
  logic [7:0] bc_dat_o;
  logic       bc_cmd_ack_i, bc_ack_i, bc_al_i;
  logic [7:0] bc_dat_i;
  logic [26:0] all_out;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] wr_plan[$];
  logic [7:0] rd_plan[$];

  always #5 clk_i = ~clk_i;

  i2c_master_xfer_seq #(.LEN_W(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .rnw_i(rnw_i),
    .dev_addr_i(dev_addr_i), .reg_addr_i(reg_addr_i), .len_i(len_i),
    .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .bc_start_o(bc_start_o), .bc_stop_o(bc_stop_o),
    .bc_read_o(bc_read_o), .bc_write_o(bc_write_o), .bc_ack_o(bc_ack_o),
    .bc_dat_o(bc_dat_o), .bc_cmd_ack_i(bc_cmd_ack_i), .bc_ack_i(bc_ack_i),
    .bc_dat_i(bc_dat_i), .bc_al_i(bc_al_i)
  );

  assign all_out = {wready_o, rdata_o, rvalid_o, busy_o, done_o, err_o,
                    bc_start_o, bc_stop_o, bc_read_o, bc_write_o, bc_ack_o, bc_dat_o};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Command record: [12]start [11]stop [10]read [9]write [8]ack_o [7:0]dat
  task automatic run_xfer(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [3:0] len, input int nack_at, input int al_at,
                          input int wdly, input int rst_after_reads);
    logic [12:0] exp_cmds[$];
    logic [7:0]  wbytes[$];
    logic [7:0]  exp_rd[$];
    logic [12:0] obs, first_obs, mask;
    logic [7:0]  rb;
    logic [1:0]  exp_err;
    int nb, idx, consumed, exp_consumed, hold, wait_cnt, reads, stray, cyc, req_hold, lim;
    logic ack_drv, al_drv, al_fired, wready_seen, done_seen, cmd_any;

    nb = int'(len) + 1;
    for (int i = 0; i < nb; i++) begin
      if (wr_plan.size() > 0) wbytes.push_back(wr_plan.pop_front());
      else wbytes.push_back(8'($urandom));
    end
    exp_cmds.push_back({4'b1001, 1'b0, dev, 1'b0});
    exp_cmds.push_back({4'b0001, 1'b0, rg});
    if (rnw) begin
      exp_cmds.push_back({4'b1001, 1'b0, dev, 1'b1});
      for (int i = 0; i < nb; i++)
        exp_cmds.push_back({1'b0, (i == nb - 1), 2'b10, (i == nb - 1), 8'h00});
    end else begin
      for (int i = 0; i < nb; i++) exp_cmds.push_back({4'b0001, 1'b0, wbytes[i]});
      exp_cmds.push_back({4'b0100, 9'h000});
    end
    if (nack_at >= 0) begin
      while (exp_cmds.size() > nack_at + 1) void'(exp_cmds.pop_back());
      exp_cmds.push_back({4'b0100, 9'h000});
    end
    lim = (al_at >= 0) ? al_at + 1 : exp_cmds.size();
    exp_consumed = 0;
    for (int i = 2; i < lim && i < exp_cmds.size(); i++)
      if (!rnw && exp_cmds[i][9]) exp_consumed++;
    if (al_at >= 0) while (exp_cmds.size() > al_at) void'(exp_cmds.pop_back());
    exp_err = {(al_at >= 0), (nack_at >= 0 && (al_at < 0 || al_at > nack_at))};

    @(posedge clk_i); #1;
    req_i = 1'b1; rnw_i = rnw; dev_addr_i = dev; reg_addr_i = rg; len_i = len;
    req_hold = int'($urandom_range(0, 1));
    @(posedge clk_i); #1;
    check("req_to_start", 32'({bc_start_o, bc_write_o, busy_o}), 32'(3'b111));

    idx = 0; consumed = 0; hold = wdly; wait_cnt = -1; reads = 0; stray = 0; cyc = 0;
    ack_drv = 1'b0; al_drv = 1'b0; al_fired = 1'b0; wready_seen = 1'b0; done_seen = 1'b0;
    first_obs = '0;
    while (cyc < 4000) begin
      if (req_hold > 0) req_hold--;
      else begin
        req_i = 1'b0; rnw_i = 1'($urandom); dev_addr_i = 7'($urandom);
        reg_addr_i = 8'($urandom); len_i = 4'($urandom);
      end
      if (wready_seen) begin consumed++; hold = wdly; end
      if (al_drv) begin
        check("al_drops_cmds", 32'({bc_start_o, bc_stop_o, bc_read_o, bc_write_o}), 32'(0));
        al_drv = 1'b0; bc_al_i = 1'b0;
      end
      if (rvalid_o) begin
        reads++;
        if (exp_rd.size() > 0) check("rdata", 32'(rdata_o), 32'(exp_rd.pop_front()));
        else stray++;
      end
      if (rst_after_reads > 0 && reads >= rst_after_reads) begin
        rst_n_i = 1'b0; bc_cmd_ack_i = 1'b0; bc_al_i = 1'b0; wvalid_i = 1'b0; req_i = 1'b0;
        #1;
        check("async_reset_mid_rd", 32'(all_out), 32'(0));
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        $display("xfer rnw=%0d dev=%h reg=%h len=%0d aborted by reset after %0d reads",
                 rnw, dev, rg, len, reads);
        return;
      end
      if (done_o) begin
        done_seen = 1'b1;
        check("done_err", 32'({busy_o, err_o}), 32'({1'b1, exp_err}));
      end else if (!busy_o) stray++;

      cmd_any = bc_start_o | bc_stop_o | bc_read_o | bc_write_o;
      obs = {bc_start_o, bc_stop_o, bc_read_o, bc_write_o, bc_ack_o, bc_dat_o};
      // a data write may not appear before its byte was taken from the host
      if (cmd_any && !rnw && idx == 2 + consumed && consumed < nb &&
          (nack_at < 0 || idx <= nack_at)) stray++;
      if (ack_drv) begin
        bc_cmd_ack_i = 1'b0; ack_drv = 1'b0; wait_cnt = -1;
      end else if (cmd_any) begin
        if (wait_cnt < 0) begin wait_cnt = int'($urandom_range(0, 3)); first_obs = obs; end
        else if (obs !== first_obs) stray++;
        if (idx == al_at && !al_fired) begin
          bc_al_i = 1'b1; al_drv = 1'b1; al_fired = 1'b1;
          if ($urandom_range(0, 1) == 1) begin bc_cmd_ack_i = 1'b1; ack_drv = 1'b1; end
        end else if (wait_cnt == 0) begin
          mask = {4'hF, 9'h000};
          if (idx < exp_cmds.size()) begin
            if (exp_cmds[idx][10]) mask[8] = 1'b1;
            if (exp_cmds[idx][9]) mask[7:0] = 8'hFF;
            check($sformatf("cmd%0d", idx), 32'(obs & mask), 32'(exp_cmds[idx] & mask));
          end else stray++;
          bc_ack_i = bc_write_o ? (idx == nack_at) : 1'($urandom);
          if (bc_read_o) begin
            if (rd_plan.size() > 0) rb = rd_plan.pop_front();
            else rb = 8'($urandom);
            bc_dat_i = rb; exp_rd.push_back(rb);
          end else bc_dat_i = 8'($urandom);
          bc_cmd_ack_i = 1'b1; ack_drv = 1'b1; idx++;
        end else wait_cnt--;
      end

      if (!rnw && consumed < nb) begin
        if (hold > 0) begin hold--; wvalid_i = 1'b0; wdata_i = 8'($urandom); end
        else begin wvalid_i = 1'b1; wdata_i = wbytes[consumed]; end
      end else begin
        wvalid_i = 1'($urandom); wdata_i = 8'($urandom);
      end
      #1;
      wready_seen = wready_o;
      if (wready_o && (rnw || consumed >= nb || !wvalid_i)) stray++;
      if (done_seen) break;
      @(posedge clk_i); #1;
      cyc++;
    end

    check("done_seen", 32'(done_seen), 32'(1));
    check("cmd_count", 32'(idx), 32'(exp_cmds.size()));
    check("reads_pending", 32'(exp_rd.size()), 32'(0));
    check("bytes_taken", 32'(consumed), 32'(exp_consumed));
    check("protocol_stray", 32'(stray), 32'(0));
    @(posedge clk_i); #1;
    check("post_done", 32'({done_o, busy_o, err_o}), 32'({2'b00, exp_err}));
    $display("xfer rnw=%0d dev=%h reg=%h len=%0d nack_at=%0d al_at=%0d wdly=%0d err=%b",
             rnw, dev, rg, len, nack_at, al_at, wdly, err_o);
  endtask

  initial begin
    logic r;
    logic [3:0] ln;
    int nbr, wtmax, sz, na, aa;

    rst_n_i = 1'b0; req_i = 1'b0; rnw_i = 1'b0; dev_addr_i = '0; reg_addr_i = '0;
    len_i = '0; wdata_i = '0; wvalid_i = 1'b0; bc_cmd_ack_i = 1'b0; bc_ack_i = 1'b0;
    bc_dat_i = '0; bc_al_i = 1'b0;
    #1;
    check("reset_outputs", 32'(all_out), 32'(0));
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_hold", 32'(all_out), 32'(0));
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    check("idle_after_reset", 32'(all_out), 32'(0));

    wr_plan = '{8'hA5, 8'h5A};
    run_xfer(1'b0, 7'h50, 8'h10, 4'd1, -1, -1, 0, 0);
    rd_plan = '{8'h11, 8'h22, 8'h33};
    run_xfer(1'b1, 7'h50, 8'h20, 4'd2, -1, -1, 0, 0);
    run_xfer(1'b0, 7'h50, 8'h10, 4'd1, 0, -1, 0, 0);
    run_xfer(1'b0, 7'h2C, 8'h44, 4'd2, -1, -1, 50, 0);
    run_xfer(1'b0, 7'h50, 8'h10, 4'd1, -1, 1, 0, 0);
    run_xfer(1'b1, 7'h50, 8'h30, 4'd3, -1, -1, 0, 2);
    run_xfer(1'b1, 7'h50, 8'h30, 4'd3, -1, -1, 0, 0);

    for (int t = 0; t < 40; t++) begin
      r     = 1'($urandom);
      ln    = 4'($urandom);
      nbr   = int'(ln) + 1;
      wtmax = r ? 2 : 1 + nbr;
      sz    = 3 + nbr;
      na    = -1;
      if ($urandom_range(0, 3) == 0) begin
        na = int'($urandom_range(0, wtmax));
        sz = na + 2;
      end
      aa = -1;
      if ($urandom_range(0, 4) == 0) aa = int'($urandom_range(0, sz - 1));
      run_xfer(r, 7'($urandom), 8'($urandom), ln, na, aa, int'($urandom_range(0, 3)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
